// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types and helpers for the AES SubBytes engine:
//                16 x 8-bit state, FSM states, byte mapping and ShiftRows.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   // One S-box byte (address or data)
   typedef logic [7:0] sbox_byte_t;

   // AES state, element i is state byte i (i = 4*col + row)
   typedef logic [15:0][7:0] aes_state_t;

   // Engine control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SUB   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } fsm_state_t;

   // LSB position of state byte i inside a 128-bit word (byte 0 is the MSB)
   function automatic logic [6:0] byte_lsb(input logic [3:0] i);
      return 7'(120 - 8 * int'(i));
   endfunction

   // Unpack a 128-bit word into state bytes
   function automatic aes_state_t word_to_state(input logic [127:0] w);
      aes_state_t s;
      for (int i = 0; i < 16; i++) begin
         s[4'(i)] = w[byte_lsb(4'(i)) +: 8];
      end
      return s;
   endfunction

   // Pack state bytes back into a 128-bit word
   function automatic logic [127:0] state_to_word(input aes_state_t s);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         w[byte_lsb(4'(i)) +: 8] = s[4'(i)];
      end
      return w;
   endfunction

   // ShiftRows: row r is rotated left by r columns
   function automatic aes_state_t shift_rows(input aes_state_t s);
      aes_state_t r;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[4'(4 * c + row)] = s[4'(4 * ((c + row) % 4) + row)];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_lane.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_lane
//  Description : One S-box lookup lane. Raises a request for its state byte
//                while the batch is active, captures the returned data on the
//                acknowledge edge and stays idle until the whole batch clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_lane
   import aes_pkg::*;
#(
   parameter int ACK_IGNORE_NOREQ = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_active,     // engine is in the SubBytes phase
   input  logic       i_ack_en,     // acks are accepted (masked just after reset)
   input  logic       i_batch_clr,  // every lane of the current batch is done
   input  sbox_byte_t i_byte,       // current state byte served by this lane
   input  logic       i_ack,
   input  sbox_byte_t i_data,
   output logic       o_req,
   output sbox_byte_t o_addr,
   output logic       o_wr,         // write i_data into the served state byte
   output sbox_byte_t o_wr_data,
   output logic       o_done        // lane finished (including a same-cycle ack)
);

   logic done_q;
   logic done_d;
   logic take;

   // Request/ack handshake and per-batch completion flag
   always_comb begin
      o_req     = i_active && !done_q;
      take      = i_active && i_ack_en && i_ack &&
                  (o_req || (ACK_IGNORE_NOREQ == 0));
      o_addr    = o_req ? i_byte : 8'h00;
      o_wr      = take;
      o_wr_data = i_data;
      o_done    = done_q || take;
      done_d    = done_q;
      if (!i_active || i_batch_clr) begin
         done_d = 1'b0;
      end else if (take) begin
         done_d = 1'b1;
      end
   end

   // Completion flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_subbytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aes_subbytes_engine
//  Description : AddRoundKey + SubBytes (+ optional ShiftRows) on one 128-bit
//                block using LANES external S-box lookup lanes.
//                Define AES_SHIFTROWS_EN to apply ShiftRows in the SHIFT state;
//                otherwise SHIFT passes the state through unchanged.
//                LANES must be 1, 2, 4, 8 or 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_subbytes_engine
   import aes_pkg::*;
#(
   parameter int LANES            = 1,
   parameter int ACK_IGNORE_NOREQ = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [127:0]         word,
   input  logic [127:0]         key,
   output logic [LANES-1:0]     sbox_req,
   output logic [8*LANES-1:0]   sbox_addr,
   input  logic [LANES-1:0]     sbox_ack,
   input  logic [8*LANES-1:0]   sbox_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [127:0]         cipher
);

   localparam int NUM_BATCH = 16 / LANES;
   localparam int BATCH_W   = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
   localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCH - 1);

   fsm_state_t         fsm_q, fsm_d;
   aes_state_t         state_q, state_d;
   logic [BATCH_W-1:0] batch_q, batch_d;
   logic               ack_en_q, ack_en_d;

   logic [3:0]         base_idx;
   logic               sub_active;
   logic               batch_done;
   logic               last_batch;
   logic [LANES-1:0]   lane_wr;
   logic [LANES-1:0]   lane_done;
   sbox_byte_t         lane_byte    [LANES];
   sbox_byte_t         lane_wr_data [LANES];

   assign base_idx   = 4'(int'(batch_q) * LANES);
   assign sub_active = (fsm_q == SUB);
   assign batch_done = sub_active && (&lane_done);
   assign last_batch = (batch_q == LAST_BATCH);
   assign cipher     = state_to_word(state_q);

   // Lookup lanes: lane l serves state byte batch*LANES + l
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_byte[l] = state_q[base_idx + 4'(l)];

      aes_sbox_lane #(
         .ACK_IGNORE_NOREQ (ACK_IGNORE_NOREQ)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .i_active    (sub_active),
         .i_ack_en    (ack_en_q),
         .i_batch_clr (batch_done),
         .i_byte      (lane_byte[l]),
         .i_ack       (sbox_ack[l]),
         .i_data      (sbox_data[8*l +: 8]),
         .o_req       (sbox_req[l]),
         .o_addr      (sbox_addr[8*l +: 8]),
         .o_wr        (lane_wr[l]),
         .o_wr_data   (lane_wr_data[l]),
         .o_done      (lane_done[l])
      );
   end

   // Next-state logic and handshake outputs
   always_comb begin
      fsm_d     = fsm_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_d = SUB;
         end
         SUB: begin
            if (batch_done && last_batch) fsm_d = SHIFT;
         end
         SHIFT: begin
            fsm_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State datapath: key add on accept, byte writes from lanes, optional ShiftRows
   always_comb begin
      state_d  = state_q;
      batch_d  = batch_q;
      ack_en_d = 1'b1;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = word_to_state(word ^ key);
               batch_d = '0;
            end
         end
         SUB: begin
            for (int l = 0; l < LANES; l++) begin
               if (lane_wr[l]) state_d[base_idx + 4'(l)] = lane_wr_data[l];
            end
            if (batch_done && !last_batch) batch_d = batch_q + 1'b1;
         end
         SHIFT: begin
`ifdef AES_SHIFTROWS_EN
            state_d = shift_rows(state_q);
`else
            state_d = state_q;
`endif
         end
         default: ;
      endcase
   end

   // Registers; ack_en_q masks acks in the first cycle after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q    <= IDLE;
         state_q  <= '0;
         batch_q  <= '0;
         ack_en_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         batch_q  <= batch_d;
         ack_en_q <= ack_en_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_subbytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_subbytes_engine
//  Description : Self-checking bench for aes_subbytes_engine with an S-box
//                responder (configurable ack delay) and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_subbytes_engine;

   localparam int LANES   = 4;
   localparam int EXP_LAT = 16 / LANES + 2;

   localparam logic [127:0] FIPS_W = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`ifdef AES_SHIFTROWS_EN
   localparam logic [127:0] FIPS_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
   localparam logic [127:0] FIPS_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [127:0]         word;
   logic [127:0]         key;
   logic [LANES-1:0]     sbox_req;
   logic [8*LANES-1:0]   sbox_addr;
   logic [LANES-1:0]     sbox_ack;
   logic [8*LANES-1:0]   sbox_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [127:0]         cipher;

   int           n_checks = 0;
   int           n_errors = 0;
   int           n_acked  = 0;
   int           cyc      = 0;
   int           accept_cyc;
   int           max_dly  = 0;
   bit           stray_en = 0;
   logic [127:0] last_exp = '0;
   logic [127:0] exp_q [$];

   bit           pend [LANES];
   int           dly  [LANES];
   logic [7:0]   held [LANES];

   aes_subbytes_engine #(
      .LANES            (LANES),
      .ACK_IGNORE_NOREQ (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .word      (word),
      .key       (key),
      .sbox_req  (sbox_req),
      .sbox_addr (sbox_addr),
      .sbox_ack  (sbox_ack),
      .sbox_data (sbox_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cipher    (cipher)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: AddRoundKey, SubBytes, optional ShiftRows
   function automatic logic [127:0] model(input logic [127:0] w, input logic [127:0] k);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] x;
      logic [127:0] r;
      x = w ^ k;
      for (int i = 0; i < 16; i++) s[i] = SBOX[x[127-8*i -: 8]];
`ifdef AES_SHIFTROWS_EN
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
`else
      t = s;
`endif
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // S-box responder: per-lane random delay, stability check, stray acks
   initial begin : responder
      sbox_ack  = '0;
      sbox_data = '0;
      for (int l = 0; l < LANES; l++) begin
         pend[l] = 0; dly[l] = 0; held[l] = '0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int l = 0; l < LANES; l++) begin
            if (rst) begin
               pend[l]     = 0;
               sbox_ack[l] = stray_en;
            end else begin
               if (sbox_ack[l] && pend[l]) pend[l] = 0;
               if (sbox_req[l]) begin
                  if (!pend[l]) begin
                     pend[l] = 1;
                     held[l] = sbox_addr[8*l +: 8];
                     dly[l]  = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
                  end else begin
                     n_checks++;
                     if (sbox_addr[8*l +: 8] !== held[l]) begin
                        n_errors++;
                        $display("FAIL addr_stable lane %0d: got %h required %h", l, sbox_addr[8*l +: 8], held[l]);
                     end
                  end
                  if (dly[l] == 0) begin
                     sbox_ack[l]         = 1'b1;
                     sbox_data[8*l +: 8] = SBOX[sbox_addr[8*l +: 8]];
                     n_acked++;
                  end else begin
                     dly[l]--;
                     sbox_ack[l] = 1'b0;
                  end
               end else begin
                  if (pend[l]) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL req_held lane %0d: req got 0 required 1 until ack", l);
                     pend[l] = 0;
                  end
                  sbox_ack[l]         = stray_en ? 1'($urandom) : 1'b0;
                  sbox_data[8*l +: 8] = 8'($urandom);
               end
            end
         end
      end
   end

   task automatic send(input logic [127:0] w, input logic [127:0] k, input logic [127:0] exp);
      int t;
      @(negedge clk);
      word     = w;
      key      = k;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!in_ready) begin
         n_errors++;
         $display("FAIL accept_timeout: in_ready got 0 required 1");
      end else begin
         exp_q.push_back(exp);
         accept_cyc = cyc;
         n_acked    = 0;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(input bit chk_lat, input int hold);
      int           t;
      logic [127:0] exp;
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!out_valid) begin
         n_errors++;
         $display("FAIL result_timeout: out_valid got 0 required 1");
         return;
      end
      if (chk_lat) begin
         n_checks++;
         if (cyc - accept_cyc != EXP_LAT) begin
            n_errors++;
            $display("FAIL latency: got %0d required %0d", cyc - accept_cyc, EXP_LAT);
         end
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL scoreboard_empty: got 0 entries required 1");
         return;
      end
      exp = exp_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
         if (h != 0) @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || cipher !== exp || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL done_hold cycle %0d: valid %b cipher %h ready %b required 1 %h 0", h, out_valid, cipher, in_ready, exp);
         end
      end
      n_checks++;
      if (n_acked != 16) begin
         n_errors++;
         $display("FAIL lookup_count: got %0d required 16", n_acked);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL return_idle: valid %b ready %b required 0 1", out_valid, in_ready);
      end
      last_exp = exp;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      stray_en  = 1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      word      = '0;
      key       = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sbox_req !== '0 ||
          sbox_addr !== '0 || cipher !== '0) begin
         n_errors++;
         $display("FAIL reset_state: ready %b valid %b req %h addr %h cipher %h required 1 0 0 0 0",
                  in_ready, out_valid, sbox_req, sbox_addr, cipher);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      stray_en = 0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || cipher !== '0) begin
         n_errors++;
         $display("FAIL post_reset_acks: ready %b valid %b cipher %h required 1 0 0", in_ready, out_valid, cipher);
      end
   endtask

   task automatic test_fips_vector();
      max_dly = 0;
      send(FIPS_W, FIPS_K, FIPS_EXP);
      collect(1, 0);
   endtask

   task automatic test_random_delays();
      logic [127:0] w, k;
      max_dly = 5;
      send(FIPS_W, FIPS_K, FIPS_EXP);
      collect(0, 0);
      for (int i = 0; i < 3; i++) begin
         w = rand128();
         k = rand128();
         send(w, k, model(w, k));
         collect(0, 0);
      end
      max_dly = 0;
   endtask

   task automatic test_back_to_back();
      logic [127:0] w, k;
      max_dly = 0;
      for (int i = 0; i < 4; i++) begin
         w = rand128();
         k = rand128();
         send(w, k, model(w, k));
         collect(1, 0);
      end
   endtask

   task automatic test_hold_done();
      logic [127:0] w, k;
      w = rand128();
      k = rand128();
      send(w, k, model(w, k));
      collect(1, 10);
   endtask

   task automatic test_stray_ack_idle();
      logic [127:0] w, k;
      stray_en = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || sbox_req !== '0 || cipher !== last_exp) begin
            n_errors++;
            $display("FAIL stray_ack_idle: ready %b valid %b req %h cipher %h required 1 0 0 %h",
                     in_ready, out_valid, sbox_req, cipher, last_exp);
         end
      end
      stray_en = 0;
      w = rand128();
      k = rand128();
      send(w, k, model(w, k));
      collect(1, 0);
   endtask

   task automatic test_reset_mid_sub();
      int           t;
      logic [127:0] w, k;
      max_dly = 2;
      send(FIPS_W, FIPS_K, FIPS_EXP);
      t = 0;
      while (n_acked < 8 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (n_acked < 8) begin
         n_errors++;
         $display("FAIL reach_batch2: acks got %0d required 8", n_acked);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (sbox_req !== '0 || sbox_addr !== '0 || out_valid !== 1'b0 ||
          in_ready !== 1'b1 || cipher !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_sub: req %h addr %h valid %b ready %b cipher %h required 0 0 0 1 0",
                  sbox_req, sbox_addr, out_valid, in_ready, cipher);
      end
      exp_q.delete();
      @(negedge clk);
      rst     = 1'b0;
      max_dly = 0;
      @(negedge clk);
      w = rand128();
      k = rand128();
      send(w, k, model(w, k));
      collect(1, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      test_reset();
      test_fips_vector();
      test_random_delays();
      test_back_to_back();
      test_hold_done();
      test_stray_ack_idle();
      test_reset_mid_sub();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_subbytes_engine.md
AES_SUBBYTES_ENGINE -- requirements
Module: aes_subbytes_engine

Interface
REQ-001 The block SHALL have parameter LANES, default 1, giving the number of parallel S-box lookup lanes; legal values are 1, 2, 4, 8 and 16.
REQ-002 The block SHALL have parameter ACK_IGNORE_NOREQ, default 1; when 1, sbox_ack on a lane without sbox_req is ignored.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: word and key are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts input.
REQ-007 The block SHALL have port word, input, 128 bits: plaintext state.
REQ-008 The block SHALL have port key, input, 128 bits: round key.
REQ-009 The block SHALL have port sbox_req, output, LANES bits: per-lane lookup request.
REQ-010 The block SHALL have port sbox_addr, output, 8*LANES bits: per-lane S-box address; lane l occupies bits [8l+7:8l].
REQ-011 The block SHALL have port sbox_ack, input, LANES bits: per-lane data-valid acknowledge.
REQ-012 The block SHALL have port sbox_data, input, 8*LANES bits: per-lane S-box result, with the same lane packing as sbox_addr.
REQ-013 The block SHALL have port out_valid, output, 1 bit: cipher is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer accepts cipher.
REQ-015 The block SHALL have port cipher, output, 128 bits: result state.

Function
REQ-016 State byte i (i = 0..15, column-major per FIPS-197, i = 4*col + row) SHALL map to word[127-8i -: 8].
REQ-017 The FSM SHALL have exactly four states, IDLE, SUB, SHIFT and DONE, and SHALL leave IDLE only on in_valid && in_ready.
REQ-018 In IDLE, in_ready SHALL be 1; on accept, the state register SHALL load word^key (AddRoundKey), the batch counter SHALL clear, and the next state SHALL be SUB.
REQ-019 In SUB, batch b SHALL serve bytes b*LANES+l on lanes l = 0..LANES-1, with 16/LANES batches in total.
REQ-020 At batch start, each lane SHALL raise sbox_req and drive its address from the current state byte; req and addr SHALL remain stable until that lane sees sbox_ack.
REQ-021 On the sbox_ack edge, a lane SHALL write sbox_data into its state byte, deassert sbox_req the following cycle, and stay idle until the batch completes.
REQ-022 Lanes SHALL complete independently; the next batch SHALL start the cycle after the last outstanding lane is acknowledged.
REQ-023 An ack arriving in the same cycle that req rises SHALL count, giving a minimum of 1 cycle per batch.
REQ-024 After the last batch, the FSM SHALL go to SHIFT; SHIFT SHALL last exactly one cycle and then go to DONE.
REQ-025 In DONE, out_valid SHALL be 1 and cipher SHALL be stable; when out_valid && out_ready, the FSM SHALL return to IDLE the next cycle.
REQ-026 in_ready SHALL be 0 in SUB, SHIFT and DONE, and new input SHALL NOT be accepted in the DONE/out_ready cycle.
REQ-027 With zero-wait acks, latency from accept to out_valid SHALL be 16/LANES + 2 cycles.

Reset
REQ-028 Asserting rst at any time, including mid-SUB, SHALL force IDLE, clear the state register and counters, and drive in_ready=1, sbox_req=0, sbox_addr=0, out_valid=0 and cipher=0.
REQ-029 Acks arriving while rst is asserted, or in the first cycle after rst deasserts, SHALL be ignored.

Configuration
REQ-030 With AES_SHIFTROWS_EN defined, SHIFT SHALL apply FIPS-197 ShiftRows (row r rotated left by r) to the state.
REQ-031 Without AES_SHIFTROWS_EN, SHIFT SHALL pass the state unchanged, so cipher = SubBytes(word^key); latency SHALL be unchanged in both cases.

Structure
REQ-032 Package aes_pkg SHALL hold the state typedef (16 x 8-bit), the FSM state enum, the byte-index mapping function and the shift_rows function.
REQ-033 Sub-module aes_sbox_lane SHALL implement one lane's request/ack handshake and SHALL be instantiated LANES times.

Verification
REQ-034 LANES=1, AES_SHIFTROWS_EN defined, zero-wait acks, word=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> cipher=d4bf5d30e0b452aeb84111f11e2798e5, out_valid 18 cycles after accept.
REQ-035 Same vectors with AES_SHIFTROWS_EN undefined and LANES=16 -> cipher=d42711aee0bf98f1b8b45de51e415230 after 3 cycles.
REQ-036 LANES=4, random 0-5 cycle ack delays per lane -> cipher still d4bf5d30...; each req/addr held stable until its ack; exactly 16 acknowledged lookups.
REQ-037 rst asserted in SUB batch 2 -> same cycle: sbox_req=0, out_valid=0, in_ready=1; a fresh vector afterwards produces the correct result.
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid and cipher stay stable and in_ready=0; stray sbox_ack pulses in IDLE cause no state change.
